// File: rtl/memio_arbiter.sv
// Two-master (CPU / loader) arbiter and sequencer for the data memory and IO bus.
// Each grant runs IDLE -> ACCESS -> RESP, strobing the device once and acking the owner.
module memio_arbiter #(
    parameter logic [21:0] IO_HI      = 22'h3FFFFF,
    parameter logic [5:0]  LED_SEL    = 6'h06,
    parameter logic [5:0]  SW_SEL     = 6'h07,
    parameter int          STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic        ld_ack,
    output logic [31:0] ld_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IORead,
    output logic        IOWrite,
    output logic        LEDCtrl,
    output logic        SwitchCtrl,
    input  logic [31:0] mem_rdata,
    input  logic [15:0] io_rdata,
    output logic        dec_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    // strobe vector: {MemRead, MemWrite, IORead, IOWrite, LEDCtrl, SwitchCtrl}
    localparam logic [5:0] ST_MR  = 6'b100000;
    localparam logic [5:0] ST_MW  = 6'b010000;
    localparam logic [5:0] ST_IOR = 6'b001001;
    localparam logic [5:0] ST_IOW = 6'b000110;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        K_NONE,
        K_MEM_RD,
        K_IO_RD,
        K_ERR
    } kind_t;

    state_t        state, state_n;
    kind_t         kind, kind_n;
    kind_t         dec_kind;
    logic          owner, owner_n;
    logic [SW-1:0] starve, starve_n;
    logic [31:0]   addr_n, wdata_n;
    logic [5:0]    strb, strb_n, dec_strb;
    logic          cpu_ack_n, ld_ack_n, err_n;
    logic          starved, grant_ld;
    logic          req_we;
    logic [31:0]   req_addr, req_wdata;
    logic          is_mem, led_wr, sw_rd;
    logic [31:0]   resp_data;
    logic [31:0]   cpu_hold, ld_hold;

    assign starved   = (starve == SW'(STARVE_MAX));
    assign grant_ld  = ld_req & (~cpu_req | starved);
    assign req_we    = grant_ld ? ld_we : cpu_we;
    assign req_addr  = grant_ld ? ld_addr : cpu_addr;
    assign req_wdata = grant_ld ? ld_wdata : cpu_wdata;

    assign is_mem = (req_addr[31:10] != IO_HI);
    assign led_wr = ~is_mem & (req_addr[9:4] == LED_SEL) & req_we;
    assign sw_rd  = ~is_mem & (req_addr[9:4] == SW_SEL) & ~req_we;

    assign {MemRead, MemWrite, IORead, IOWrite, LEDCtrl, SwitchCtrl} = strb;

    assign cpu_stall = cpu_req & ~cpu_ack;
    assign cpu_rdata = cpu_ack ? resp_data : cpu_hold;
    assign ld_rdata  = ld_ack ? resp_data : ld_hold;

    // Decode the request about to be granted into strobes and response kind.
    always_comb begin
        dec_strb = '0;
        dec_kind = K_ERR;
        unique case (1'b1)
            is_mem: begin
                dec_strb = req_we ? ST_MW : ST_MR;
                dec_kind = req_we ? K_NONE : K_MEM_RD;
            end
            led_wr: begin
                dec_strb = ST_IOW;
                dec_kind = K_NONE;
            end
            sw_rd: begin
                dec_strb = ST_IOR;
                dec_kind = K_IO_RD;
            end
            default: begin
                dec_strb = '0;
                dec_kind = K_ERR;
            end
        endcase
    end

    // Next-state, arbitration and next values of all registered outputs.
    always_comb begin
        state_n   = state;
        owner_n   = owner;
        kind_n    = kind;
        starve_n  = starve;
        addr_n    = mem_addr;
        wdata_n   = mem_wdata;
        strb_n    = '0;
        cpu_ack_n = 1'b0;
        ld_ack_n  = 1'b0;
        err_n     = 1'b0;
        unique case (state)
            IDLE: begin
                if (ld_req & ~grant_ld)
                    starve_n = starved ? starve : starve + SW'(1);
                else
                    starve_n = '0;
                if (cpu_req | ld_req) begin
                    state_n = ACCESS;
                    owner_n = grant_ld;
                    kind_n  = dec_kind;
                    addr_n  = req_addr;
                    wdata_n = req_wdata;
                    strb_n  = dec_strb;
                end
            end
            ACCESS: begin
                state_n   = RESP;
                cpu_ack_n = ~owner;
                ld_ack_n  = owner;
                err_n     = (kind == K_ERR);
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Read data presented to the owner during its ack cycle.
    always_comb begin
        resp_data = '0;
        unique case (kind)
            K_MEM_RD: resp_data = mem_rdata;
            K_IO_RD:  resp_data = {16'h0, io_rdata};
            default:  resp_data = '0;
        endcase
    end

    // Sequencer state, captured request and registered strobes/acks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            kind      <= K_NONE;
            starve    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            strb      <= '0;
            cpu_ack   <= 1'b0;
            ld_ack    <= 1'b0;
            dec_err   <= 1'b0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            kind      <= kind_n;
            starve    <= starve_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            strb      <= strb_n;
            cpu_ack   <= cpu_ack_n;
            ld_ack    <= ld_ack_n;
            dec_err   <= err_n;
        end
    end

    // Each master keeps its last read data until its next ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_hold <= '0;
            ld_hold  <= '0;
        end else begin
            if (cpu_ack)
                cpu_hold <= resp_data;
            if (ld_ack)
                ld_hold <= resp_data;
        end
    end

endmodule

// File: tb/tb_memio_arbiter.sv
// Randomized bench for memio_arbiter with a transaction-level reference model.
// Directed scenarios cover reset abort, IO decode, errors and loader starvation.
module tb_memio_arbiter;

    localparam int STARVE_MAX = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       r_req = '0;
    logic [1:0]       r_we  = '0;
    logic [1:0][31:0] r_addr  = '0;
    logic [1:0][31:0] r_wdata = '0;

    logic        cpu_ack, cpu_stall, ld_ack, dec_err;
    logic [31:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata;
    logic        MemRead, MemWrite, IORead, IOWrite, LEDCtrl, SwitchCtrl;
    logic [31:0] mem_rdata = '0;
    logic [15:0] io_rdata  = '0;

    memio_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (r_req[0]),
        .cpu_we    (r_we[0]),
        .cpu_addr  (r_addr[0]),
        .cpu_wdata (r_wdata[0]),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .ld_req    (r_req[1]),
        .ld_we     (r_we[1]),
        .ld_addr   (r_addr[1]),
        .ld_wdata  (r_wdata[1]),
        .ld_ack    (ld_ack),
        .ld_rdata  (ld_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IORead    (IORead),
        .IOWrite   (IOWrite),
        .LEDCtrl   (LEDCtrl),
        .SwitchCtrl(SwitchCtrl),
        .mem_rdata (mem_rdata),
        .io_rdata  (io_rdata),
        .dec_err   (dec_err)
    );

    // Synchronous data memory stub, one cycle read latency.
    logic [31:0] stub_mem [256];
    always @(posedge clk) begin
        if (MemWrite)
            stub_mem[mem_addr[9:2]] <= mem_wdata;
        if (MemRead)
            mem_rdata <= stub_mem[mem_addr[9:2]];
    end

    // reference model state
    logic [31:0] ref_mem [256];
    int          cyc = 0;
    int          free_at = 0;
    int          starve = 0;
    logic        t_act = 1'b0;
    int          t_g = -10;
    logic        t_ld, t_we;
    logic [31:0] t_addr, t_wdata;
    logic [5:0]  t_str;
    int          t_kind;
    logic [31:0] cpu_hold = '0, ld_hold = '0;
    logic [31:0] last_addr = '0, last_wdata = '0;
    int          mst[2] = '{0, 0};
    logic [1:0]  done = '0;
    logic        mess_en = 1'b0;
    logic        io_fix = 1'b0;
    req_t        cq[$];
    req_t        lq[$];
    int          obs[$];
    int          n_decerr = 0;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // kind: 0 no data, 1 memory read, 2 IO read, 3 illegal IO
    function automatic void decode(input logic we, input logic [31:0] a,
                                   output logic [5:0] s, output int k);
        if (a[31:10] != 22'h3FFFFF) begin
            s = we ? 6'b010000 : 6'b100000;
            k = we ? 0 : 1;
        end else if (a[9:4] == 6'h06 && we) begin
            s = 6'b000110;
            k = 0;
        end else if (a[9:4] == 6'h07 && !we) begin
            s = 6'b001001;
            k = 2;
        end else begin
            s = 6'b000000;
            k = 3;
        end
    endfunction

    function automatic req_t rand_req();
        req_t        r;
        logic [31:0] a;
        a = $urandom;
        case ($urandom_range(0, 6))
            0, 1, 2: a = {22'h0, a[9:2], 2'b00};
            3:       a[31] = 1'b0;
            4:       a = {22'h3FFFFF, 6'h06, a[3:0]};
            5:       a = {22'h3FFFFF, 6'h07, a[3:0]};
            default: a = {22'h3FFFFF, a[9:0]};
        endcase
        r.we    = 1'($urandom_range(0, 1));
        r.addr  = a;
        r.wdata = $urandom;
        return r;
    endfunction

    task automatic check_outputs();
        logic [5:0]  es;
        logic        ea_c, ea_l, ee;
        logic [31:0] resp;
        es   = '0;
        ea_c = 1'b0;
        ea_l = 1'b0;
        ee   = 1'b0;
        resp = '0;
        if (t_act && cyc == t_g + 1)
            es = t_str;
        if (t_act && cyc == t_g + 2) begin
            ee = (t_kind == 3);
            if (t_kind == 1)
                resp = ref_mem[t_addr[9:2]];
            else if (t_kind == 2)
                resp = {16'h0, io_rdata};
            if (t_ld) begin
                ea_l    = 1'b1;
                ld_hold = resp;
            end else begin
                ea_c     = 1'b1;
                cpu_hold = resp;
            end
            if (t_we && t_addr[31:10] != 22'h3FFFFF)
                ref_mem[t_addr[9:2]] = t_wdata;
            done[t_ld] = 1'b1;
            t_act = 1'b0;
        end
        chk("strobes", {26'h0, MemRead, MemWrite, IORead, IOWrite,
                        LEDCtrl, SwitchCtrl}, {26'h0, es});
        chk("cpu_ack", 32'(cpu_ack), 32'(ea_c));
        chk("ld_ack", 32'(ld_ack), 32'(ea_l));
        chk("dec_err", 32'(dec_err), 32'(ee));
        chk("cpu_rdata", cpu_rdata, cpu_hold);
        chk("ld_rdata", ld_rdata, ld_hold);
        chk("mem_addr", mem_addr, last_addr);
        chk("mem_wdata", mem_wdata, last_wdata);
        chk("cpu_stall", 32'(cpu_stall), 32'(r_req[0] & ~ea_c));
        if (cpu_ack)
            obs.push_back(0);
        if (ld_ack)
            obs.push_back(1);
        if (dec_err)
            n_decerr++;
    endtask

    task automatic drive_master(input int m);
        req_t t;
        if (mst[m] == 2 && done[m]) begin
            mst[m]  = 0;
            done[m] = 1'b0;
        end
        if (mst[m] == 0) begin
            if (m == 0 ? cq.size() > 0 : lq.size() > 0) begin
                if (m == 0)
                    t = cq.pop_front();
                else
                    t = lq.pop_front();
                r_req[m]   = 1'b1;
                r_we[m]    = t.we;
                r_addr[m]  = t.addr;
                r_wdata[m] = t.wdata;
                mst[m]     = 1;
            end else begin
                r_req[m] = 1'b0;
            end
        end else if (mst[m] == 2 && mess_en) begin
            if ($urandom_range(0, 3) == 0)
                r_req[m] = 1'b0;
            r_we[m]    = 1'($urandom_range(0, 1));
            r_addr[m]  = $urandom;
            r_wdata[m] = $urandom;
        end
    endtask

    // Arbitration decision for a cycle in which the sequencer is free.
    task automatic decide();
        logic cr, lr, gl;
        if (cyc < free_at)
            return;
        cr = r_req[0];
        lr = r_req[1];
        gl = lr && (!cr || starve == STARVE_MAX);
        if (lr && !gl)
            starve = (starve == STARVE_MAX) ? starve : starve + 1;
        else
            starve = 0;
        if (cr || lr) begin
            t_ld    = gl;
            t_we    = r_we[gl];
            t_addr  = r_addr[gl];
            t_wdata = r_wdata[gl];
            decode(t_we, t_addr, t_str, t_kind);
            last_addr  = t_addr;
            last_wdata = t_wdata;
            mst[gl]    = 2;
            t_act      = 1'b1;
            t_g        = cyc;
            free_at    = cyc + 3;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        if (!rst) begin
            drive_master(0);
            drive_master(1);
            decide();
        end
        if (!io_fix && cyc != t_g + 1 && cyc != t_g + 2)
            io_rdata = 16'($urandom);
        cyc++;
    endtask

    task automatic reset_model();
        t_act      = 1'b0;
        starve     = 0;
        cpu_hold   = '0;
        ld_hold    = '0;
        last_addr  = '0;
        last_wdata = '0;
        mst        = '{0, 0};
        done       = '0;
        r_req      = '0;
        free_at    = 0;
        cq.delete();
        lq.delete();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        reset_model();
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic run_idle(input int bound);
        int n;
        n = 0;
        while ((cq.size() > 0 || lq.size() > 0 || mst[0] != 0 ||
                mst[1] != 0 || t_act) && n < bound) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(n >= bound), 32'h0);
    endtask

    logic [31:0] init8;

    initial begin
        int n;
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ref_mem[i]  = v;
            stub_mem[i] <= v;
        end
        init8 = ref_mem[8];

        do_reset(3);
        repeat (2) step();

        // reset in the middle of a CPU write access
        cq.push_back('{we: 1'b1, addr: 32'h20, wdata: 32'hCAFEF00D});
        n = 0;
        while (!t_act && n < 20) begin
            step();
            n++;
        end
        step();
        rst = 1'b1;
        #1;
        chk("rst_memwrite", 32'(MemWrite), 32'h0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'h0);
        reset_model();
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();

        // memory write then readback, and the aborted write left no trace
        cq.push_back('{we: 1'b1, addr: 32'h10, wdata: 32'hDEADBEEF});
        cq.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
        run_idle(50);
        chk("readback", cpu_rdata, 32'hDEADBEEF);
        cq.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'h0});
        run_idle(50);
        chk("aborted_write", cpu_rdata, init8);

        // LED write
        cq.push_back('{we: 1'b1, addr: 32'hFFFFFC60, wdata: 32'h00A5A5A5});
        run_idle(50);
        chk("led_wdata", mem_wdata, 32'h00A5A5A5);

        // switch read
        io_fix   = 1'b1;
        io_rdata = 16'h1234;
        cq.push_back('{we: 1'b0, addr: 32'hFFFFFC70, wdata: 32'h0});
        run_idle(50);
        chk("sw_rdata", cpu_rdata, 32'h00001234);
        io_fix = 1'b0;

        // both masters requesting back to back
        obs.delete();
        for (int i = 0; i < 10; i++)
            cq.push_back(rand_req());
        for (int i = 0; i < 3; i++)
            lq.push_back(rand_req());
        run_idle(200);
        chk("arb_count", 32'(obs.size()), 32'd13);
        for (int i = 0; i < 13 && i < obs.size(); i++)
            chk("arb_order", 32'(obs[i]), 32'(i == 4 || i == 9 || i == 12));

        // loader access to an unknown IO select
        n_decerr = 0;
        lq.push_back('{we: 1'b1, addr: 32'hFFFFFC80, wdata: 32'h5555});
        run_idle(50);
        chk("dec_err_count", 32'(n_decerr), 32'd1);
        chk("ld_rdata_err", ld_rdata, 32'h0);

        // randomized traffic with dropped requests and post-grant input churn
        mess_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (cq.size() == 0 && $urandom_range(0, 2) == 0)
                cq.push_back(rand_req());
            if (lq.size() == 0 && $urandom_range(0, 3) == 0)
                lq.push_back(rand_req());
            step();
        end
        run_idle(200);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/memio_arbiter.md
Name: memio_arbiter

Overview:
- Two-master arbiter and sequencer for the shared data-memory/IO subsystem (dmemory32, LED and switch controllers).
- Masters: the CPU data port and a loader port (UART/JTAG program-data loader).
- Per granted transaction: decodes memory vs IO, drives the MemRead/MemWrite/IORead/IOWrite/LEDCtrl/SwitchCtrl strobes for exactly one cycle, captures read data and acks the owner.
- CPU stalls while its request is pending.

Parameters:
- IO_HI, 22'h3FFFFF: address[31:10] value selecting IO space.
- LED_SEL, 6'h06: address[9:4] selecting the LED controller (0xFFFFFC60).
- SW_SEL, 6'h07: address[9:4] selecting the switch controller (0xFFFFFC70).
- STARVE_MAX, 4: consecutive lost arbitrations after which the loader wins.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU request; held until cpu_ack.
- cpu_we  in  1  1 = write.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read data, valid with cpu_ack.
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational).
- ld_req, ld_we, ld_addr[31:0], ld_wdata[31:0]  in  loader request, same rules as CPU.
- ld_ack  out  1  completion pulse.
- ld_rdata  out  32  read data, valid with ld_ack.
- mem_addr  out  32  address to memory/IO.
- mem_wdata  out  32  write data to memory/IO.
- MemRead, MemWrite, IORead, IOWrite  out  1 each  access strobes.
- LEDCtrl, SwitchCtrl  out  1 each  IO device selects.
- mem_rdata  in  32  dmemory32 read data; one-cycle synchronous latency.
- io_rdata  in  16  IO read data; valid in the cycle after IORead.
- dec_err  out  1  one-cycle pulse on an illegal IO access.

Behaviour:
- Reset: FSM=IDLE, all strobes/acks/dec_err=0, rdata outputs=0, mem_addr/mem_wdata=0, starve counter=0. Reset mid-transaction aborts it; no ack is issued.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Fixed 3-cycle transaction; ack asserted in RESP. A new grant is possible in the IDLE cycle immediately after RESP.
- IDLE:
  - Sample requests. If only one master requests, it is granted.
  - If both request: CPU wins, unless starve counter == STARVE_MAX, then loader wins.
  - Register owner, we, addr and wdata. Later changes on the owner's inputs are ignored.
- Starve counter: +1 (saturating at STARVE_MAX) when the loader requests and loses; cleared when the loader is granted or ld_req=0 in IDLE.
- ACCESS: mem_addr/mem_wdata driven from the registered values. Exactly one strobe is high for one cycle, per decode:
  - addr[31:10]!=IO_HI: MemRead (we=0) or MemWrite (we=1).
  - IO with addr[9:4]==LED_SEL and write: IOWrite + LEDCtrl.
  - IO with addr[9:4]==SW_SEL and read: IORead + SwitchCtrl.
  - Any other IO access (unknown select, LED read, switch write): no strobe; dec_err pulses in RESP.
- RESP:
  - Owner ack=1 for one cycle.
  - Read data: memory read = mem_rdata; IO read = {16'h0, io_rdata}; error = 32'h0.
  - Owner rdata holds its value until that owner's next ack.
  - Non-owner ack stays 0.
- Strobes are registered outputs (glitch-free), high only in ACCESS.
- A request dropped before its ack is still completed; the ack is ignored by the master.
- mem_addr/mem_wdata hold their last value outside ACCESS.

Test Plan:
- Reset pulse mid-ACCESS of a CPU write -> MemWrite deasserts immediately, no cpu_ack, FSM in IDLE at release.
- CPU write 0x00000010 <= 0xDEADBEEF, then read it back -> MemWrite one cycle; read ack 2 cycles after grant with cpu_rdata=0xDEADBEEF; cpu_stall high until ack.
- CPU write 0xFFFFFC60 <= 0x00A5A5A5 -> IOWrite+LEDCtrl one cycle, mem_wdata=0x00A5A5A5.
- CPU read 0xFFFFFC70 with io_rdata=16'h1234 -> IORead+SwitchCtrl one cycle; cpu_rdata=0x00001234.
- CPU and loader both requesting continuously -> CPU granted 4 times, then loader once, repeating; no double ack; no strobes outside ACCESS.
- Loader write to 0xFFFFFC80 -> no strobe, dec_err pulse, ld_ack with ld_rdata=0.
